// File: rtl/klotski_pkg.sv
// Shared definitions for the klotski block sampler.
//   state_t     : sampler FSM states
//   NUM_BLOCKS  : number of board cells (GRID x GRID)
//   CH_R/G/B    : channel index within a packed 24-bit RGB word (byte lane)
package klotski_pkg;

  localparam int NUM_BLOCKS = 16;
  localparam int GRID       = 4;

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_ACC,
    S_AVG,
    S_START,
    S_WAIT_DONE
  } state_t;

endpackage

// File: rtl/klotski_cell_acc.sv
// One board cell: window-hit compare plus a 3-channel unsigned accumulator.
// Ports:
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_clear              : synchronous clear of all three sums
//   i_en                 : accumulate enable (frame window open)
//   i_pix_valid/x/y/rgb  : pixel stream
//   o_sum[ch]            : running sum per channel, indexed by CH_R/CH_G/CH_B
module klotski_cell_acc
  import klotski_pkg::*;
#(
  parameter int X0    = 0,
  parameter int Y0    = 0,
  parameter int WIN   = 8,
  parameter int ACC_W = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic                  i_pix_valid,
  input  logic [11:0]           i_pix_x,
  input  logic [11:0]           i_pix_y,
  input  logic [23:0]           i_pix_rgb,
  output logic [2:0][ACC_W-1:0] o_sum
);

  localparam logic [11:0] X_LO = 12'(X0);
  localparam logic [11:0] X_HI = 12'(X0 + WIN);
  localparam logic [11:0] Y_LO = 12'(Y0);
  localparam logic [11:0] Y_HI = 12'(Y0 + WIN);

  logic                  w_hit;
  logic [2:0][ACC_W-1:0] r_sum;

  assign w_hit = i_pix_valid &&
                 (i_pix_x >= X_LO) && (i_pix_x < X_HI) &&
                 (i_pix_y >= Y_LO) && (i_pix_y < Y_HI);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_en && w_hit) begin
      for (int unsigned ch = 0; ch < 3; ch++) begin
        r_sum[ch] <= r_sum[ch] + ACC_W'(i_pix_rgb[ch*8 +: 8]);
      end
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/klotski_block_sampler.sv
// Samples one camera frame over a 4x4 grid, averages a centred square window
// per cell, starts the sorter and captures its piece-order word.
// Ports:
//   i_clk, i_rst_n           : clock, async active-low reset
//   i_capture                : request sampling of the next frame (ignored when busy)
//   i_sof, i_pix_*           : pixel stream with start-of-frame pulse
//   o_block0..o_block15      : averaged cell colours, row-major, RGB packed
//   o_start                  : one-cycle sorter start pulse
//   i_done, i_order          : sorter completion pulse and order word
//   o_order, o_order_valid   : captured order word and its update pulse
//   o_busy                   : high whenever not idle
//   o_error                  : one-cycle pulse on sorter timeout
module klotski_block_sampler
  import klotski_pkg::*;
#(
  parameter int ORG_X        = 160,
  parameter int ORG_Y        = 80,
  parameter int CELL         = 80,
  parameter int WIN_LOG2     = 3,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_capture,
  input  logic        i_sof,
  input  logic        i_pix_valid,
  input  logic [11:0] i_pix_x,
  input  logic [11:0] i_pix_y,
  input  logic [23:0] i_pix_rgb,
  output logic [23:0] o_block0,
  output logic [23:0] o_block1,
  output logic [23:0] o_block2,
  output logic [23:0] o_block3,
  output logic [23:0] o_block4,
  output logic [23:0] o_block5,
  output logic [23:0] o_block6,
  output logic [23:0] o_block7,
  output logic [23:0] o_block8,
  output logic [23:0] o_block9,
  output logic [23:0] o_block10,
  output logic [23:0] o_block11,
  output logic [23:0] o_block12,
  output logic [23:0] o_block13,
  output logic [23:0] o_block14,
  output logic [23:0] o_block15,
  output logic        o_start,
  input  logic        i_done,
  input  logic [63:0] i_order,
  output logic [63:0] o_order,
  output logic        o_order_valid,
  output logic        o_busy,
  output logic        o_error
);

  localparam int WIN   = 2**WIN_LOG2;
  localparam int ACC_W = 8 + 2*WIN_LOG2;
  localparam int OFS   = (CELL - WIN) / 2;
  localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);

  state_t                                r_state, w_next;
  logic                                  w_clear, w_acc_en, w_done_hit, w_timeout;
  logic [CNT_W-1:0]                      r_cnt, w_cnt_inc;
  logic [NUM_BLOCKS-1:0][2:0][ACC_W-1:0] w_sum;
  logic [NUM_BLOCKS-1:0][23:0]           r_block;
  logic [63:0]                           r_order;
  logic                                  r_order_valid, r_error;

  for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_cell
    klotski_cell_acc #(
      .X0    (ORG_X + (k % GRID) * CELL + OFS),
      .Y0    (ORG_Y + (k / GRID) * CELL + OFS),
      .WIN   (WIN),
      .ACC_W (ACC_W)
    ) u_cell (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clear     (w_clear),
      .i_en        (w_acc_en),
      .i_pix_valid (i_pix_valid),
      .i_pix_x     (i_pix_x),
      .i_pix_y     (i_pix_y),
      .i_pix_rgb   (i_pix_rgb),
      .o_sum       (w_sum[k])
    );
  end

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // The opening sof pixel is accumulated; the closing sof pixel is not.
  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    w_acc_en   = 1'b0;
    w_done_hit = 1'b0;
    w_timeout  = 1'b0;
    o_start    = 1'b0;
    o_busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (i_capture) begin
          w_clear = 1'b1;
          w_next  = S_WAIT_SOF;
        end
      end
      S_WAIT_SOF: begin
        if (i_sof) begin
          w_acc_en = 1'b1;
          w_next   = S_ACC;
        end
      end
      S_ACC: begin
        if (i_sof) w_next   = S_AVG;
        else       w_acc_en = 1'b1;
      end
      S_AVG:   w_next = S_START;
      S_START: begin
        o_start = 1'b1;
        w_next  = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // done takes priority over a coincident timeout
        if (i_done) begin
          w_done_hit = 1'b1;
          w_next     = S_IDLE;
        end else if (w_cnt_inc == CNT_W'(DONE_TIMEOUT)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_START) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT_DONE && !i_done) begin
      r_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_block <= '0;
    end else if (r_state == S_AVG) begin
      for (int unsigned k = 0; k < NUM_BLOCKS; k++) begin
        for (int unsigned ch = 0; ch < 3; ch++) begin
          r_block[k][ch*8 +: 8] <= 8'(w_sum[k][ch] >> (2*WIN_LOG2));
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_order       <= '0;
      r_order_valid <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_order_valid <= w_done_hit;
      r_error       <= w_timeout;
      if (w_done_hit) r_order <= i_order;
    end
  end

  assign o_order       = r_order;
  assign o_order_valid = r_order_valid;
  assign o_error       = r_error;

  assign o_block0  = r_block[0];
  assign o_block1  = r_block[1];
  assign o_block2  = r_block[2];
  assign o_block3  = r_block[3];
  assign o_block4  = r_block[4];
  assign o_block5  = r_block[5];
  assign o_block6  = r_block[6];
  assign o_block7  = r_block[7];
  assign o_block8  = r_block[8];
  assign o_block9  = r_block[9];
  assign o_block10 = r_block[10];
  assign o_block11 = r_block[11];
  assign o_block12 = r_block[12];
  assign o_block13 = r_block[13];
  assign o_block14 = r_block[14];
  assign o_block15 = r_block[15];

endmodule

// File: doc/klotski_block_sampler.md
Name: klotski_block_sampler

Overview:
- Front end and initiator for the klotski RGB sorter. It samples one frame of the camera pixel stream over a 4x4 board grid and averages a fixed square window in each cell, giving 16 24-bit block colours.
- It then issues the sorter's start handshake, holds the block colours stable, and waits for the sorter's done pulse. On done it captures the 64-bit piece-order word for the solver and display logic.

Parameters:
- ORG_X, 160: x coordinate of the grid's left edge, in pixels.
- ORG_Y, 80: y coordinate of the grid's top edge, in pixels.
- CELL, 80: cell pitch in pixels. Must satisfy CELL >= 2**WIN_LOG2.
- WIN_LOG2, 3: the sample window is 2**WIN_LOG2 square (8x8 = 64 pixels), centred in each cell.
- DONE_TIMEOUT, 255: maximum cycles to wait for i_done before aborting.

Ports:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: reset. Reset is asynchronous and active-low.
- i_capture, input, 1: single-cycle request to sample the next frame.
- i_sof, input, 1: start-of-frame pulse, coincident with or preceding pixel (0,0).
- i_pix_valid, input, 1: pixel qualifier.
- i_pix_x, input, 12: pixel column.
- i_pix_y, input, 12: pixel row.
- i_pix_rgb, input, 24: pixel colour, R [23:16], G [15:8], B [7:0].
- o_block0 .. o_block15, output, 24 each: averaged cell colours. Block k is row k/4, column k%4. Same RGB packing as i_pix_rgb.
- o_start, output, 1: single-cycle start pulse to the sorter.
- i_done, input, 1: sorter done pulse.
- i_order, input, 64: sorter order word. Position 0 is in [63:60].
- o_order, output, 64: captured order word.
- o_order_valid, output, 1: single-cycle pulse when o_order is updated.
- o_busy, output, 1: high in every state except S_IDLE.
- o_error, output, 1: single-cycle pulse on timeout.

Behaviour:
- Reset values: all o_block = 0, o_order = 0, all pulses = 0, o_busy = 0, state = S_IDLE. The accumulators and the timeout counter are also cleared.
- Window for cell (r,c):
  - x in [ORG_X + c*CELL + (CELL - W)/2, +W), where W = 2**WIN_LOG2.
  - y in [ORG_Y + r*CELL + (CELL - W)/2, +W).
  - A valid pixel hits at most one cell. Pixels outside every window are ignored.
- Accumulators: 16 cells x 3 channels, each 8 + 2*WIN_LOG2 bits wide, unsigned. They cannot overflow.
- States and transitions:
  - S_IDLE: when i_capture is high, clear all accumulators and go to S_WAIT_SOF.
  - S_WAIT_SOF: when i_sof is high, go to S_ACC. A pixel arriving in the same cycle as i_sof is accumulated.
  - S_ACC: on each valid hit, add that pixel's R, G and B to the hit cell's accumulators. When the next i_sof arrives, go to S_AVG; pixels in that cycle are not accumulated.
  - S_AVG (1 cycle): o_blockk = {sumR, sumG, sumB} >> 2*WIN_LOG2, truncated. Registered here; go to S_START.
  - S_START (1 cycle): o_start = 1, clear the timeout counter, go to S_WAIT_DONE.
  - S_WAIT_DONE:
    - If i_done is high, capture o_order = i_order, pulse o_order_valid on the next cycle, and go to S_IDLE.
    - Otherwise increment the counter. When it reaches DONE_TIMEOUT, pulse o_error, keep o_order unchanged, and go to S_IDLE.
- o_block registers change only in S_AVG. They stay stable from o_start until the next capture's S_AVG, because the sorter latches its inputs on start.
- i_capture is ignored while o_busy is high. It is not queued.
- An i_done outside S_WAIT_DONE is ignored.
- If i_done arrives in the same cycle the counter reaches DONE_TIMEOUT, the done wins: no error is raised.
- If reset asserts mid-operation, all state returns to reset values immediately. Partial sums are discarded.
- Latency from the closing i_sof to o_start is 2 cycles.

Decomposition:
- Package klotski_pkg holds:
  - the sampler state enum (S_IDLE, S_WAIT_SOF, S_ACC, S_AVG, S_START, S_WAIT_DONE);
  - NUM_BLOCKS = 16 and GRID = 4;
  - the channel index constants CH_R = 2, CH_G = 1, CH_B = 0.
- Sub-module klotski_cell_acc holds one cell's window-hit compare and its 3-channel accumulator, with clear, enable and sum outputs. The sampler instantiates it 16 times in a generate loop.

Test Plan:
- Uniform colour: frame of all 0x4080C0, capture → all 16 o_block = 0x4080C0 and exactly one o_start pulse. Sorter model returns i_order = 0x0123456789ABCDEF → o_order matches it and o_order_valid pulses once.
- Distinct cells: cell k filled with R = 16*k, G = 255 - 16*k, B = k → each o_blockk matches its cell exactly, and pixels outside the windows (set to 0xFFFFFF) have no effect.
- Truncation: within cell 5, half the window pixels have R = 3 and half R = 4 → R = 3 (224 >> 6).
- Timeout: no i_done after o_start → o_error pulses 255 cycles after S_WAIT_DONE is entered, o_order keeps its previous value, and o_busy falls.
- Busy and stray pulses: i_capture during S_ACC is ignored; a stray i_done in S_IDLE causes no o_order_valid; a capture followed by i_done within 10 cycles gives one o_order_valid.
- Reset: i_rst_n low mid-S_ACC → outputs return to 0 immediately. A new capture afterwards gives correct averages with no residue from the partial frame.
